bios_boot_loader: RTL and testbench
===================================

// Module: bios_boot_loader
// PURPOSE
//   Boot sequencer for the single-cycle MIPS. After reset it copies the BIOS ROM image word by word
//   into instruction memory, holding the CPU stalled meanwhile. When the copy ends it asserts
//   changeSource so instruction fetch moves from BIOS to instruction memory, then releases the CPU.
//   Sits between the BIOS ROM (registered read, 1-cycle latency), instruction memory write port and CPU.
// PARAMETERS
//   DATA_WIDTH   32  width of BIOS words, addresses and the instruction memory bus
//   BIOS_WORDS   41  number of BIOS words to copy (1..2^DATA_WIDTH-1)
//   DEST_BASE    0   instruction memory word address receiving BIOS word 0
// PORTS
//   clock         in   1           system clock; BIOS ROM read clock is tied to this same clock
//   rst           in   1           asynchronous reset, active-low
//   start         in   1           begin copy; sampled only in IDLE
//   bios_addr     out  DATA_WIDTH  BIOS ROM word address
//   bios_data     in   DATA_WIDTH  BIOS ROM data, valid 1 cycle after bios_addr is presented
//   imem_addr     out  DATA_WIDTH  instruction memory write address
//   imem_wdata    out  DATA_WIDTH  instruction memory write data
//   imem_we       out  1           write request; held until imem_ready
//   imem_ready    in   1           write accepted this cycle when imem_we && imem_ready
//   cpu_hold      out  1           stall CPU (PC frozen)
//   changeSource  out  1           1 = fetch from instruction memory, 0 = fetch from BIOS
//   busy          out  1           copy in progress
//   done          out  1           copy finished successfully
//   expected_sum  in   DATA_WIDTH  golden checksum (used only with BOOT_CHECKSUM_EN)
//   checksum_err  out  1           checksum mismatch (BOOT_CHECKSUM_EN only, else constant 0)
// BEHAVIOUR
//   Reset (rst=0, asynchronous): state=IDLE, idx=0, all outputs 0 except cpu_hold=1.
//   States: IDLE, REQ, WAIT, WRITE, DONE (plus ERR with checksum option).
//   IDLE : cpu_hold=1. start=1 at an edge -> REQ. start=0 -> stay.
//   REQ  : bios_addr=idx, busy=1 -> WAIT next edge.
//   WAIT : bios_addr=idx held. bios_data is valid and latched into imem_wdata at this edge -> WRITE.
//   WRITE: imem_we=1, imem_addr=DEST_BASE+idx, imem_wdata stable. Stay while imem_ready=0.
//          On accept: if idx==BIOS_WORDS-1 -> DONE, else idx<=idx+1 -> REQ.
//   DONE : busy=0, done=1, changeSource=1, cpu_hold=0. Sticky until reset; start ignored.
//   Address math: DATA_WIDTH bits, modulo 2^DATA_WIDTH. DEST_BASE+idx wrap is not detected.
//   Latency: with imem_ready tied 1, 3 cycles per word. done rises 3*BIOS_WORDS edges after the
//     start edge (123 for the default). Each imem_ready=0 cycle adds 1.
//   Boundaries: start while busy/DONE ignored. BIOS_WORDS=1 -> single write, then DONE.
//     imem_ready never high -> remains in WRITE with busy=1 (no timeout).
//     rst low mid-copy -> immediate IDLE, partial image abandoned, changeSource=0, cpu_hold=1.
//     imem_we is never asserted outside WRITE. Exactly one write per word.
// CONFIGURATION
//   BOOT_CHECKSUM_EN defined:
//     - 32-bit wrapping sum of every accepted word, cleared in IDLE.
//     - After the last write: sum==expected_sum -> DONE.
//     - Else -> ERR: checksum_err=1, busy=0, done=0, cpu_hold=1, changeSource=0.
//       Sticky until reset.
//   BOOT_CHECKSUM_EN undefined: no accumulator. expected_sum is ignored, checksum_err=0.
//     Copy always ends in DONE.
// TESTING
//   1. Reset, BIOS_WORDS=41, ready=1, start pulse -> 41 writes at addr 0..40 matching ROM;
//      done=1, changeSource=1 at edge 123.
//   2. ready low 2 cycles on word 5 -> imem_we/addr/wdata held stable; 1 write for word 5;
//      done at edge 125.
//   3. rst low at edge 60, then release, then start -> outputs at reset values, full copy
//      restarts from addr 0.
//   4. start pulses during copy and in DONE -> no effect on sequence, count or done timing.
//   5. BIOS_WORDS=1, DEST_BASE=0x100 -> single write at 0x100, done at edge 3.
//   6. BOOT_CHECKSUM_EN, expected_sum correct -> DONE. Off by 1 -> checksum_err=1,
//      cpu_hold=1, done=0.

Source files
------------

// File: rtl/bios_boot_loader.sv
// Boot sequencer: copies the BIOS ROM image into instruction memory, then moves fetch to
// instruction memory and releases the CPU. Optional checksum guard: BOOT_CHECKSUM_EN.
module bios_boot_loader #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           BIOS_WORDS = 41,
    parameter logic [DATA_WIDTH-1:0] DEST_BASE  = '0
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] bios_addr,
    input  logic [DATA_WIDTH-1:0] bios_data,
    output logic [DATA_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  imem_we,
    input  logic                  imem_ready,
    output logic                  cpu_hold,
    output logic                  changeSource,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] expected_sum,
    output logic                  checksum_err
);

    localparam logic [DATA_WIDTH-1:0] LAST_IDX = DATA_WIDTH'(BIOS_WORDS - 32'd1);
    localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [DATA_WIDTH-1:0] idx_r;
    logic [DATA_WIDTH-1:0] idx_s;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] wdata_s;
    logic [DATA_WIDTH-1:0] bios_addr_r;
    logic [DATA_WIDTH-1:0] imem_addr_r;
    logic [DATA_WIDTH-1:0] imem_addr_s;
    logic                  we_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  hold_r;
    logic                  change_r;
    logic                  last_s;

    assign last_s = (idx_r == LAST_IDX);

`ifdef BOOT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_r;
    logic [DATA_WIDTH-1:0] sum_s;
    logic [DATA_WIDTH-1:0] sum_add_s;
    logic                  err_r;
    logic                  accept_s;

    assign accept_s  = (state_r == ST_WRITE) && imem_ready;
    assign sum_add_s = sum_r + wdata_r;

    // Running sum of accepted words; cleared while idle
    always_comb begin
        sum_s = sum_r;
        if (state_r == ST_IDLE) begin
            sum_s = '0;
        end else if (accept_s) begin
            sum_s = sum_add_s;
        end else begin
            sum_s = sum_r;
        end
    end

    // Checksum accumulator and sticky error flag
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            sum_r <= '0;
            err_r <= 1'b0;
        end else begin
            sum_r <= sum_s;
            err_r <= (state_s == ST_ERR);
        end
    end

    assign checksum_err = err_r;
`else
    logic unused_expected_sum_s;
    assign unused_expected_sum_s = ^expected_sum;
    assign checksum_err          = 1'b0;
`endif

    // FSM state, word index and captured ROM word
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            wdata_r <= '0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            wdata_r <= wdata_s;
        end
    end

    // Next-state decode; the ROM word is valid in WAIT because the ROM read is registered
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        wdata_s = wdata_r;
        case (state_r)
            ST_IDLE: begin
                idx_s = '0;
                if (start) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                wdata_s = bios_data;
                state_s = ST_WRITE;
            end
            ST_WRITE: begin
                if (!imem_ready) begin
                    state_s = ST_WRITE;
                end else if (last_s) begin
`ifdef BOOT_CHECKSUM_EN
                    if (sum_add_s == expected_sum) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ERR;
                    end
`else
                    state_s = ST_DONE;
`endif
                end else begin
                    idx_s   = idx_r + ONE;
                    state_s = ST_REQ;
                end
            end
            ST_DONE: begin
                state_s = ST_DONE;
            end
            ST_ERR: begin
                state_s = ST_ERR;
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = '0;
            end
        endcase
    end

    // Write address only moves when a write is being presented, so it holds through stalls
    always_comb begin
        imem_addr_s = imem_addr_r;
        if (state_s == ST_WRITE) begin
            imem_addr_s = DEST_BASE + idx_s;
        end else begin
            imem_addr_s = imem_addr_r;
        end
    end

    // Outputs registered from the next state so they are a clean decode of the current state
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            we_r        <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            hold_r      <= 1'b1;
            change_r    <= 1'b0;
            bios_addr_r <= '0;
            imem_addr_r <= '0;
        end else begin
            we_r        <= (state_s == ST_WRITE);
            busy_r      <= (state_s == ST_REQ) || (state_s == ST_WAIT) || (state_s == ST_WRITE);
            done_r      <= (state_s == ST_DONE);
            hold_r      <= (state_s != ST_DONE);
            change_r    <= (state_s == ST_DONE);
            bios_addr_r <= idx_s;
            imem_addr_r <= imem_addr_s;
        end
    end

    assign bios_addr    = bios_addr_r;
    assign imem_addr    = imem_addr_r;
    assign imem_wdata   = wdata_r;
    assign imem_we      = we_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign cpu_hold     = hold_r;
    assign changeSource = change_r;

endmodule

// File: tb/tb_bios_boot_loader.sv
// Self-checking bench for bios_boot_loader: a 41-word instance checked every cycle against a
// word-slot model, plus a 1-word instance at base 0x100 checked with literal expectations.
`timescale 1ns/1ps
module tb_bios_boot_loader;

    localparam int          NA     = 41;
    localparam logic [31:0] BASE_B = 32'h0000_0100;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rom_sum(input int n);
        logic [31:0] s;
        s = 32'h0;
        for (int i = 0; i < n; i++) s = s + rom_word(32'(i));
        return s;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instance A: 41 words at base 0 ----------------
    logic        rst_a, start_a, ready_a;
    logic [31:0] bios_addr_a, bios_data_a, imem_addr_a, imem_wdata_a, esum_a;
    logic        we_a, hold_a, cs_a, busy_a, done_a, err_a;

    bios_boot_loader #(.DATA_WIDTH(32), .BIOS_WORDS(NA), .DEST_BASE(32'h0)) dut_a (
        .clock(clock), .rst(rst_a), .start(start_a),
        .bios_addr(bios_addr_a), .bios_data(bios_data_a),
        .imem_addr(imem_addr_a), .imem_wdata(imem_wdata_a), .imem_we(we_a), .imem_ready(ready_a),
        .cpu_hold(hold_a), .changeSource(cs_a), .busy(busy_a), .done(done_a),
        .expected_sum(esum_a), .checksum_err(err_a)
    );

    always @(posedge clock) bios_data_a <= rom_word(bios_addr_a);

    // Model: each word is two set-up edges then a write slot that lasts until ready is seen
    bit m_run = 1'b0;
    bit m_done = 1'b0;
    int m_words = 0;
    int m_lead = 0;
    bit a_counting = 1'b0;
    int a_edges = 0;
    int a_done_at = -1;
    int a_wr_cnt = 0;

    always @(posedge clock or negedge rst_a) begin
        if (!rst_a) begin
            m_run = 1'b0; m_done = 1'b0; m_words = 0; m_lead = 0; a_counting = 1'b0;
        end else begin
            if (a_counting) a_edges++;
            if (!m_run && !m_done) begin
                if (start_a) begin
                    m_run = 1'b1; m_lead = 2; a_counting = 1'b1; a_edges = 0;
                end
            end else if (m_run) begin
                if (m_lead > 0) m_lead--;
                else if (ready_a) begin
                    m_words++;
                    if (m_words == NA) begin m_run = 1'b0; m_done = 1'b1; end
                    else m_lead = 2;
                end
            end
        end
    end

    always @(negedge clock) begin
        logic exp_we;
        exp_we = m_run && (m_lead == 0);
        check1("a_we", we_a, exp_we);
        check1("a_busy", busy_a, m_run);
        check1("a_done", done_a, m_done);
        check1("a_changeSource", cs_a, m_done);
        check1("a_cpu_hold", hold_a, !m_done);
        check1("a_checksum_err", err_a, 1'b0);
        if (exp_we) begin
            check32("a_imem_addr", imem_addr_a, 32'(m_words));
            check32("a_imem_wdata", imem_wdata_a, rom_word(32'(m_words)));
        end
        if (we_a && ready_a) a_wr_cnt++;
        if (done_a && a_counting && a_done_at < 0) a_done_at = a_edges;
    end

    // ---------------- instance B: 1 word at base 0x100 ----------------
    logic        rst_b, start_b, ready_b;
    logic [31:0] bios_addr_b, bios_data_b, imem_addr_b, imem_wdata_b, esum_b;
    logic        we_b, hold_b, cs_b, busy_b, done_b, err_b;

    bios_boot_loader #(.DATA_WIDTH(32), .BIOS_WORDS(1), .DEST_BASE(BASE_B)) dut_b (
        .clock(clock), .rst(rst_b), .start(start_b),
        .bios_addr(bios_addr_b), .bios_data(bios_data_b),
        .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b), .imem_we(we_b), .imem_ready(ready_b),
        .cpu_hold(hold_b), .changeSource(cs_b), .busy(busy_b), .done(done_b),
        .expected_sum(esum_b), .checksum_err(err_b)
    );

    always @(posedge clock) bios_data_b <= rom_word(bios_addr_b);

    bit          b_counting = 1'b0;
    int          b_edges = 0;
    int          b_done_at = -1;
    int          b_wr_cnt = 0;
    logic [31:0] b_last_addr = 32'h0;
    logic [31:0] b_last_data = 32'h0;

    always @(posedge clock or negedge rst_b) begin
        if (!rst_b) b_counting = 1'b0;
        else begin
            if (b_counting) b_edges++;
            else if (start_b) begin b_counting = 1'b1; b_edges = 0; end
        end
    end

    always @(negedge clock) begin
        if (we_b && ready_b) begin
            b_wr_cnt++; b_last_addr = imem_addr_b; b_last_data = imem_wdata_b;
        end
        if (done_b && b_counting && b_done_at < 0) b_done_at = b_edges;
    end

    // ---------------- directed sequence ----------------
    task automatic pulse_start_a;
        @(posedge clock); #2 start_a = 1'b1;
        @(posedge clock); #2 start_a = 1'b0;
    endtask

    task automatic reset_a;
        @(posedge clock); #2 rst_a = 1'b0; a_wr_cnt = 0; a_done_at = -1;
        @(posedge clock); #2 rst_a = 1'b1;
    endtask

    task automatic wait_done_a(input string name, input int budget);
        int n;
        n = 0;
        while (!done_a && n < budget) begin @(posedge clock); #3; n++; end
        check1(name, done_a, 1'b1);
        @(negedge clock); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        ready_a = 1'b1; ready_b = 1'b1;
        esum_a = rom_sum(NA); esum_b = 32'h5A5A_0F0F;
        repeat (2) @(posedge clock); #3;
        check1("rst_cpu_hold", hold_a, 1'b1);
        check1("rst_busy", busy_a, 1'b0);
        check1("rst_done", done_a, 1'b0);
        check1("rst_changeSource", cs_a, 1'b0);
        check1("rst_imem_we", we_a, 1'b0);
        check32("rst_imem_addr", imem_addr_a, 32'h0);
        check32("rst_bios_addr", bios_addr_a, 32'h0);
        @(posedge clock); #2 rst_a = 1'b1; rst_b = 1'b1;

        // plain copy, ready always high
        pulse_start_a;
        wait_done_a("t1_done_reached", 300);
        check32("t1_done_edge", 32'(a_done_at), 32'd123);
        check32("t1_write_count", 32'(a_wr_cnt), 32'd41);
        check1("t1_changeSource", cs_a, 1'b1);
        check1("t1_cpu_hold", hold_a, 1'b0);

        // two stall cycles on word 5, start pulses during copy and in DONE
        reset_a;
        pulse_start_a;
        repeat (17) @(posedge clock);
        #2 ready_a = 1'b0;
        repeat (2) @(posedge clock);
        #2 ready_a = 1'b1;
        repeat (10) @(posedge clock);
        #2 start_a = 1'b1;
        @(posedge clock); #2 start_a = 1'b0;
        wait_done_a("t2_done_reached", 300);
        check32("t2_done_edge", 32'(a_done_at), 32'd125);
        check32("t2_write_count", 32'(a_wr_cnt), 32'd41);
        pulse_start_a;
        repeat (5) @(posedge clock); #3;
        check1("t2_done_sticky", done_a, 1'b1);
        check32("t2_write_count_after", 32'(a_wr_cnt), 32'd41);

        // asynchronous reset mid-copy, then a full restart
        reset_a;
        pulse_start_a;
        repeat (59) @(posedge clock);
        #2 rst_a = 1'b0;
        #1;
        check1("t3_rst_cpu_hold", hold_a, 1'b1);
        check1("t3_rst_busy", busy_a, 1'b0);
        check1("t3_rst_changeSource", cs_a, 1'b0);
        check1("t3_rst_imem_we", we_a, 1'b0);
        check32("t3_rst_imem_addr", imem_addr_a, 32'h0);
        a_wr_cnt = 0; a_done_at = -1;
        @(posedge clock); #2 rst_a = 1'b1;
        pulse_start_a;
        wait_done_a("t3_done_reached", 300);
        check32("t3_done_edge", 32'(a_done_at), 32'd123);
        check32("t3_write_count", 32'(a_wr_cnt), 32'd41);

        // single-word image at base 0x100, correct checksum
        @(posedge clock); #2 start_b = 1'b1;
        @(posedge clock); #2 start_b = 1'b0;
        repeat (6) @(posedge clock);
        @(negedge clock); #1;
        check32("t5_done_edge", 32'(b_done_at), 32'd3);
        check32("t5_write_count", 32'(b_wr_cnt), 32'd1);
        check32("t5_write_addr", b_last_addr, 32'h0000_0100);
        check32("t5_write_data", b_last_data, 32'h5A5A_0F0F);
        check1("t5_done", done_b, 1'b1);
        check1("t5_checksum_err", err_b, 1'b0);

        // same image with a golden sum off by one
        @(posedge clock); #2 rst_b = 1'b0; b_wr_cnt = 0; b_done_at = -1; esum_b = 32'h5A5A_0F10;
        @(posedge clock); #2 rst_b = 1'b1;
        @(posedge clock); #2 start_b = 1'b1;
        @(posedge clock); #2 start_b = 1'b0;
        repeat (6) @(posedge clock); #3;
        check32("t6_write_count", 32'(b_wr_cnt), 32'd1);
        check1("t6_busy", busy_b, 1'b0);
`ifdef BOOT_CHECKSUM_EN
        check1("t6_checksum_err", err_b, 1'b1);
        check1("t6_cpu_hold", hold_b, 1'b1);
        check1("t6_done", done_b, 1'b0);
        check1("t6_changeSource", cs_b, 1'b0);
`else
        check1("t6_checksum_err", err_b, 1'b0);
        check1("t6_cpu_hold", hold_b, 1'b0);
        check1("t6_done", done_b, 1'b1);
        check1("t6_changeSource", cs_b, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
